piso_serializer: RTL and testbench

//  Parallel-in/serial-out stage that feeds the 16:1 gate-level mux.
//  - Accepts a 16-bit word via valid/ready.
//  - Steps the mux select 0..15 and streams one bit per downstream handshake.
//  - Sits between a word producer (register/ALU side) and a bit-serial consumer.

---
 rtl/piso_pkg.sv | 25 ++
 rtl/mux16to1.sv | 18 +
 rtl/piso_serializer.sv | 142 ++++++++++++++
 tb/tb_piso_serializer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Package: piso_pkg
// Shared constants and state encoding for the parallel-in/serial-out stage
// and its 16:1 select mux.
//
// Configuration macro: PISO_PARITY_EN adds the PAR state, in which an even
// parity bit is appended after the 16 data bits.
package piso_pkg;

   localparam int WIDTH = 16;
   localparam int SEL_W = 4;

   localparam logic [SEL_W-1:0] SEL_FIRST = '0;
   localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(WIDTH - 1);
   localparam logic [SEL_W-1:0] SEL_STEP  = SEL_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01
`ifdef PISO_PARITY_EN
      ,
      PAR   = 2'b10
`endif
   } state_t;

endpackage

// File: rtl/mux16to1.sv
// Module: mux16to1
// 16:1 select mux that picks one bit of a word.
//
// Ports:
//   in   [0:15]  word to select from; index 0 is chosen by sel=0
//   sel  [0:3]   select value; sel[0] is the MSB
//   out          the selected bit, in[sel]
module mux16to1
   import piso_pkg::*;
(
   input  logic [0:WIDTH-1] in,
   input  logic [0:SEL_W-1] sel,
   output logic             out
);

   assign out = in[sel];

endmodule

// File: rtl/piso_serializer.sv
// Module: piso_serializer
// Parallel-in/serial-out stage. A 16-bit word is accepted over a
// valid/ready handshake, then streamed one bit per downstream handshake by
// stepping the select of a 16:1 mux from 0 to 15. Bit 0 goes out first.
// One idle cycle separates consecutive frames.
//
// Configuration macro: PISO_PARITY_EN
//   defined   - even parity of the word is captured with it and sent as a
//               17th bit (PAR state); ser_last marks the parity bit.
//   undefined - 16-bit frames; ser_last marks bit 15.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst_n      asynchronous active-low reset
//   in_data    [0:15] parallel word, bit 0 sent first
//   in_valid   producer has a word
//   in_ready   stage can accept a word (only while idle)
//   ser_out    current serial bit
//   ser_valid  ser_out is valid
//   ser_ready  consumer takes ser_out this cycle
//   sel        [0:3] current mux select, sel[0] is the MSB
//   ser_last   current bit is the final bit of the frame
module piso_serializer
   import piso_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [0:WIDTH-1] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic [0:SEL_W-1] sel,
   output logic             ser_last
);

   state_t           state_q, state_d;
   logic [0:SEL_W-1] sel_q, sel_d;
   logic [0:WIDTH-1] word_q, word_d;
   logic             muxBit;

`ifdef PISO_PARITY_EN
   logic             parity_q, parity_d;
`endif

   mux16to1 u_mux (
      .in  (word_q),
      .sel (sel_q),
      .out (muxBit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sel_q    <= SEL_FIRST;
         word_q   <= '0;
`ifdef PISO_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         word_q   <= word_d;
`ifdef PISO_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Outputs are decoded from the state register alone, so an asynchronous
   // reset returns them to their idle values without waiting for a clock.
   // The word register only loads while idle, which makes in_data changes
   // during a frame invisible.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      word_d    = word_q;
`ifdef PISO_PARITY_EN
      parity_d  = parity_q;
`endif
      in_ready  = 1'b0;
      ser_valid = 1'b0;
      ser_out   = 1'b0;
      ser_last  = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               word_d   = in_data;
               sel_d    = SEL_FIRST;
`ifdef PISO_PARITY_EN
               parity_d = ^in_data;
`endif
               state_d  = SHIFT;
            end
         end

         SHIFT: begin
            ser_valid = 1'b1;
            ser_out   = muxBit;
`ifndef PISO_PARITY_EN
            ser_last  = (sel_q == SEL_LAST);
`endif
            if (ser_ready) begin
               if (sel_q != SEL_LAST) begin
                  sel_d = sel_q + SEL_STEP;
               end else begin
`ifdef PISO_PARITY_EN
                  // sel stays at 15 while the parity bit is presented
                  state_d = PAR;
`else
                  state_d = IDLE;
                  sel_d   = SEL_FIRST;
`endif
               end
            end
         end

`ifdef PISO_PARITY_EN
         PAR: begin
            ser_valid = 1'b1;
            ser_out   = parity_q;
            ser_last  = 1'b1;
            if (ser_ready) begin
               state_d = IDLE;
               sel_d   = SEL_FIRST;
            end
         end
`endif

         default: begin
            state_d = IDLE;
            sel_d   = SEL_FIRST;
         end
      endcase
   end

   assign sel = sel_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: table-driven frames with hand-computed
// bit streams and parity, plus hand-written sequences for accept gating,
// idle ser_ready and asynchronous reset mid-frame.
module tb_piso_serializer;

   logic        clk;
   logic        rst_n;
   logic [0:15] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        ser_out;
   logic        ser_valid;
   logic        ser_ready;
   logic [0:3]  sel;
   logic        ser_last;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [0:15] word;
      logic [0:15] stream;
      logic        parity;
      int          stallAt;
   } vec_t;

   vec_t vecs[5];

   piso_serializer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ser_out   (ser_out),
      .ser_valid (ser_valid),
      .ser_ready (ser_ready),
      .sel       (sel),
      .ser_last  (ser_last)
   );

   // 10-unit clock; posedge at 5, 15, ...; outputs are sampled on negedges
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compares one observed value against its hand-computed expectation
   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Sends one word with ser_ready high and checks every bit of the frame,
   // optionally stalling ser_ready for three cycles at bit stallAt
   task automatic applyStimulus(input vec_t v);
      logic expLast;
      @(negedge clk);
      checkOutput("idle in_ready", in_ready, 16'd1);
      in_data   = v.word;
      in_valid  = 1'b1;
      ser_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i == 0) in_valid = 1'b0;
`ifdef PISO_PARITY_EN
         expLast = 1'b0;
`else
         expLast = (i == 15);
`endif
         checkOutput("bit ser_valid", ser_valid, 16'd1);
         checkOutput("bit in_ready", in_ready, 16'd0);
         checkOutput("bit sel", sel, 16'(i));
         checkOutput("bit ser_out", ser_out, v.stream[i]);
         checkOutput("bit ser_last", ser_last, expLast);
         if (i == v.stallAt) begin
            ser_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               checkOutput("stall sel", sel, 16'(i));
               checkOutput("stall ser_out", ser_out, v.stream[i]);
               checkOutput("stall ser_valid", ser_valid, 16'd1);
               checkOutput("stall ser_last", ser_last, expLast);
            end
            ser_ready = 1'b1;
         end
      end
`ifdef PISO_PARITY_EN
      @(negedge clk);
      checkOutput("par ser_valid", ser_valid, 16'd1);
      checkOutput("par ser_out", ser_out, v.parity);
      checkOutput("par ser_last", ser_last, 16'd1);
      checkOutput("par sel", sel, 16'd15);
`endif
      @(negedge clk);
      checkOutput("bubble in_ready", in_ready, 16'd1);
      checkOutput("bubble ser_valid", ser_valid, 16'd0);
      checkOutput("bubble ser_last", ser_last, 16'd0);
      checkOutput("bubble sel", sel, 16'd0);
   endtask

   initial begin
      vecs[0] = '{word: 16'h8001, stream: 16'b1000000000000001, parity: 1'b0, stallAt: -1};
      vecs[1] = '{word: 16'hA5A5, stream: 16'b1010010110100101, parity: 1'b0, stallAt: 5};
      vecs[2] = '{word: 16'h0007, stream: 16'b0000000000000111, parity: 1'b1, stallAt: -1};
      vecs[3] = '{word: 16'h0003, stream: 16'b0000000000000011, parity: 1'b0, stallAt: -1};
      vecs[4] = '{word: 16'h1234, stream: 16'b0001001000110100, parity: 1'b1, stallAt: 12};

      rst_n     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      ser_ready = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset in_ready", in_ready, 16'd1);
      checkOutput("reset ser_valid", ser_valid, 16'd0);
      checkOutput("reset sel", sel, 16'd0);
      checkOutput("reset ser_last", ser_last, 16'd0);
      checkOutput("reset ser_out", ser_out, 16'd0);
      rst_n = 1'b1;

      // Table-driven frames
      for (int n = 0; n < 5; n++) begin
         applyStimulus(vecs[n]);
      end

      // ser_ready while idle must not move the select
      ser_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("idle ready sel", sel, 16'd0);
         checkOutput("idle ready ser_valid", ser_valid, 16'd0);
      end

      // Accept gating: in_valid stays high and in_data changes mid-frame
      @(negedge clk);
      in_data  = 16'h8001;
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i == 3) in_data = 16'hFFFF;
         checkOutput("gate in_ready", in_ready, 16'd0);
         checkOutput("gate ser_out", ser_out, (i == 0 || i == 15) ? 16'd1 : 16'd0);
      end
`ifdef PISO_PARITY_EN
      @(negedge clk);
      checkOutput("gate par ser_out", ser_out, 16'd0);
`endif
      @(negedge clk);
      checkOutput("gate bubble in_ready", in_ready, 16'd1);
      checkOutput("gate bubble ser_valid", ser_valid, 16'd0);
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("gate second ser_valid", ser_valid, 16'd1);
      checkOutput("gate second sel", sel, 16'd0);
      checkOutput("gate second ser_out", ser_out, 16'd1);
      for (int i = 1; i < 16; i++) begin
         @(negedge clk);
         checkOutput("gate second bits", ser_out, 16'd1);
      end
`ifdef PISO_PARITY_EN
      @(negedge clk);
      checkOutput("gate second parity", ser_out, 16'd0);
`endif
      @(negedge clk);
      checkOutput("gate second bubble", in_ready, 16'd1);

      // Asynchronous reset at sel=7, between clock edges
      @(negedge clk);
      in_data  = 16'h00FF;
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      checkOutput("areset pre sel", sel, 16'd7);
      checkOutput("areset pre ser_valid", ser_valid, 16'd1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("areset ser_valid", ser_valid, 16'd0);
      checkOutput("areset in_ready", in_ready, 16'd1);
      checkOutput("areset sel", sel, 16'd0);
      checkOutput("areset ser_last", ser_last, 16'd0);
      checkOutput("areset ser_out", ser_out, 16'd0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post reset in_ready", in_ready, 16'd1);
      checkOutput("post reset ser_valid", ser_valid, 16'd0);
      checkOutput("post reset sel", sel, 16'd0);

      // A fresh frame runs normally after the aborted one
      applyStimulus(vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
